// File: rtl/seg7_spi_encoder.sv
// SPI-slave receiver that turns serialized active-low 7-segment frames back into
// decimal digits, presented through a valid/ready output register.
module seg7_spi_encoder #(
  parameter int unsigned FRAME_BITS  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  input  logic       out_ready,
  output logic [3:0] digit,
  output logic       dp,
  output logic       seg_err,
  output logic       out_valid,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned CNT_W = $clog2(FRAME_BITS + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE, WAIT_CS} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [FRAME_BITS-1:0]   shreg;
  logic [SYNC_STAGES-1:0]  sclk_sync;
  logic [SYNC_STAGES-1:0]  cs_sync;
  logic [SYNC_STAGES-1:0]  mosi_sync;
  logic                    sclk_prev;
  logic                    sclk_s;
  logic                    cs_s;
  logic                    mosi_s;
  logic                    sclk_rise;
  logic [3:0]              enc_digit_c;
  logic                    enc_err_c;

  // Pin synchronizers; chip select resets to the deasserted level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_prev <= sclk_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;

  // Exact-match glyph decode; the dp bit is excluded.
  always_comb begin
    enc_err_c = 1'b0;
    case (shreg[6:0])
      7'h40:   enc_digit_c = 4'd0;
      7'h79:   enc_digit_c = 4'd1;
      7'h24:   enc_digit_c = 4'd2;
      7'h30:   enc_digit_c = 4'd3;
      7'h19:   enc_digit_c = 4'd4;
      7'h12:   enc_digit_c = 4'd5;
      7'h02:   enc_digit_c = 4'd6;
      7'h78:   enc_digit_c = 4'd7;
      7'h00:   enc_digit_c = 4'd8;
      7'h18:   enc_digit_c = 4'd9;
      default: begin
        enc_digit_c = 4'hF;
        enc_err_c   = 1'b1;
      end
    endcase
  end

  // Frame FSM and output register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      digit     <= 4'hF;
      dp        <= 1'b0;
      seg_err   <= 1'b0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!cs_s) begin
            state <= SHIFT;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          if (cs_s) begin
            frame_err <= 1'b1;
            cnt       <= '0;
            shreg     <= '0;
            state     <= IDLE;
          end else if (sclk_rise) begin
            shreg <= {shreg[FRAME_BITS-2:0], mosi_s};
            cnt   <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(FRAME_BITS - 1)) state <= DONE;
          end
        end
        DONE: begin
          // A held, unaccepted frame wins; the new one is dropped.
          if (!out_valid || out_ready) begin
            digit     <= enc_digit_c;
            dp        <= ~shreg[FRAME_BITS-1];
            seg_err   <= enc_err_c;
            out_valid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
          state <= cs_s ? IDLE : WAIT_CS;
        end
        WAIT_CS: begin
          if (cs_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
